// File: rtl/poseidon2_req_master.sv
// Requester front end for the Poseidon2 hash core: packs a valid/ready element stream into
// 15 lanes, launches the core, returns the hash. Optional watchdog: POSEIDON2_REQ_TIMEOUT_EN.
module poseidon2_req_master #(
  parameter int ELEM_W      = 256,
  parameter int MAX_ELEMS   = 15,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ELEM_W-1:0] s_data,
  input  logic              s_last,
  output logic [3:0]        size,
  output logic              start,
  output logic [ELEM_W-1:0] data_in_0,
  output logic [ELEM_W-1:0] data_in_1,
  output logic [ELEM_W-1:0] data_in_2,
  output logic [ELEM_W-1:0] data_in_3,
  output logic [ELEM_W-1:0] data_in_4,
  output logic [ELEM_W-1:0] data_in_5,
  output logic [ELEM_W-1:0] data_in_6,
  output logic [ELEM_W-1:0] data_in_7,
  output logic [ELEM_W-1:0] data_in_8,
  output logic [ELEM_W-1:0] data_in_9,
  output logic [ELEM_W-1:0] data_in_10,
  output logic [ELEM_W-1:0] data_in_11,
  output logic [ELEM_W-1:0] data_in_12,
  output logic [ELEM_W-1:0] data_in_13,
  output logic [ELEM_W-1:0] data_in_14,
  input  logic [ELEM_W-1:0] hash_out,
  input  logic              done,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ELEM_W-1:0] m_hash,
  output logic [3:0]        m_size,
  output logic [1:0]        m_err
);

  typedef enum logic [2:0] {ST_COLLECT, ST_DRAIN, ST_FIRE, ST_WAIT, ST_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic [3:0]        size_q;
  logic              ovf_q;
  logic [ELEM_W-1:0] hash_q;
  logic [3:0]        msize_q;
  logic [ELEM_W-1:0] lane_q [15];
  logic [ELEM_W-1:0] lane_out [15];
  logic              acc;
  logic              tmo;
  logic              to_err;

  assign acc = s_valid && s_ready;

`ifdef POSEIDON2_REQ_TIMEOUT_EN
  logic [12:0] wd_q;
  logic        to_q;

  assign tmo    = (state_q == ST_WAIT) && !done && (wd_q == 13'(TIMEOUT_CYC - 1));
  assign to_err = to_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != ST_WAIT) wd_q <= '0;
    else                           wd_q <= wd_q + 13'd1;
    if (rst || (state_q == ST_RESP && m_ready)) to_q <= 1'b0;
    else if (tmo)                               to_q <= 1'b1;
  end
`else
  assign tmo    = 1'b0;
  assign to_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (acc) begin
        if (s_last)                             state_d = ST_FIRE;
        else if (cnt_q == 4'(MAX_ELEMS - 1))    state_d = ST_DRAIN;
      end
      ST_DRAIN:   if (acc && s_last)            state_d = ST_FIRE;
      ST_FIRE:                                  state_d = ST_WAIT;
      ST_WAIT:    if (done || tmo)              state_d = ST_RESP;
      ST_RESP:    if (m_ready)                  state_d = ST_COLLECT;
      default:                                  state_d = ST_COLLECT;
    endcase
  end

  always_comb begin
    s_ready = (state_q == ST_COLLECT) || (state_q == ST_DRAIN);
    start   = (state_q == ST_FIRE);
    m_valid = (state_q == ST_RESP);
  end

  // Lanes and size are only published once the message is complete, keeping the core bundle stable.
  always_ff @(posedge clk) begin
    if (rst || (state_q == ST_RESP && m_ready)) begin
      cnt_q  <= '0;
      size_q <= '0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < 15; i++) lane_q[i] <= '0;
    end else if (state_q == ST_COLLECT && acc) begin
      for (int i = 0; i < 15; i++)
        if (cnt_q == 4'(i)) lane_q[i] <= s_data;
      cnt_q <= cnt_q + 4'd1;
      if (s_last) size_q <= cnt_q + 4'd1;
      else if (cnt_q == 4'(MAX_ELEMS - 1)) ovf_q <= 1'b1;
    end else if (state_q == ST_DRAIN && acc && s_last) begin
      size_q <= cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hash_q  <= '0;
      msize_q <= '0;
    end else if (state_q == ST_WAIT && done) begin
      hash_q  <= hash_out;
      msize_q <= size_q;
    end else if (tmo) begin
      hash_q  <= '0;
      msize_q <= size_q;
    end
  end

  always_comb begin
    for (int i = 0; i < 15; i++)
      lane_out[i] = (4'(i) < size_q) ? lane_q[i] : '0;
  end

  assign size       = size_q;
  assign m_hash     = hash_q;
  assign m_size     = msize_q;
  assign m_err      = {to_err, ovf_q};
  assign data_in_0  = lane_out[0];
  assign data_in_1  = lane_out[1];
  assign data_in_2  = lane_out[2];
  assign data_in_3  = lane_out[3];
  assign data_in_4  = lane_out[4];
  assign data_in_5  = lane_out[5];
  assign data_in_6  = lane_out[6];
  assign data_in_7  = lane_out[7];
  assign data_in_8  = lane_out[8];
  assign data_in_9  = lane_out[9];
  assign data_in_10 = lane_out[10];
  assign data_in_11 = lane_out[11];
  assign data_in_12 = lane_out[12];
  assign data_in_13 = lane_out[13];
  assign data_in_14 = lane_out[14];

endmodule

// File: tb/tb_poseidon2_req_master.sv
// Directed bench for poseidon2_req_master: packing, overflow, done filtering, backpressure, reset abort.
module tb_poseidon2_req_master;

  localparam int W = 256;

  logic         clk = 1'b0;
  logic         rst, s_valid, s_last, done, m_ready;
  logic         s_ready, start, m_valid;
  logic [W-1:0] s_data, hash_out, m_hash;
  logic [3:0]   size, m_size;
  logic [1:0]   m_err;
  logic [W-1:0] d0, d1, d2, d3, d4, d5, d6, d7, d8, d9, d10, d11, d12, d13, d14;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [W-1:0] EA = {8{32'hA0A0_0001}};
  localparam logic [W-1:0] EB = {8{32'hB0B0_0002}};
  localparam logic [W-1:0] EC = {8{32'hC0C0_0003}};
  localparam logic [W-1:0] H1 = {8{32'hDEAD_BEEF}};
  localparam logic [W-1:0] H2 = {8{32'h1234_5678}};
  localparam logic [W-1:0] HX = {8{32'hBAD0_BAD0}};

  poseidon2_req_master dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .size(size), .start(start),
    .data_in_0(d0), .data_in_1(d1), .data_in_2(d2), .data_in_3(d3), .data_in_4(d4),
    .data_in_5(d5), .data_in_6(d6), .data_in_7(d7), .data_in_8(d8), .data_in_9(d9),
    .data_in_10(d10), .data_in_11(d11), .data_in_12(d12), .data_in_13(d13), .data_in_14(d14),
    .hash_out(hash_out), .done(done), .m_valid(m_valid), .m_ready(m_ready),
    .m_hash(m_hash), .m_size(m_size), .m_err(m_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [W-1:0] d, input logic last);
    s_valid = 1'b1; s_data = d; s_last = last;
    step();
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
  endtask

  task automatic pulse_done(input logic [W-1:0] h);
    done = 1'b1; hash_out = h;
    step();
    done = 1'b0; hash_out = '0;
  endtask

  task automatic handshake();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
  endtask

  logic [W-1:0] held;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    done = 1'b0; hash_out = '0; m_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_s_ready", W'(s_ready), W'(1));
    chk("rst_start",   W'(start),   W'(0));
    chk("rst_m_valid", W'(m_valid), W'(0));
    chk("rst_size",    W'(size),    W'(0));
    chk("rst_m_err",   W'(m_err),   W'(0));
    chk("rst_m_hash",  m_hash,      '0);
    chk("rst_lane0",   d0,          '0);

    // 1: three elements, done 5 cycles after start
    beat(EA, 1'b0); beat(EB, 1'b0); beat(EC, 1'b1);
    chk("t1_start", W'(start), W'(1));
    chk("t1_size",  W'(size),  W'(3));
    chk("t1_lane0", d0, EA);
    chk("t1_lane1", d1, EB);
    chk("t1_lane2", d2, EC);
    chk("t1_lane3", d3, '0);
    chk("t1_lane14", d14, '0);
    step();
    chk("t1_start_once", W'(start), W'(0));
    chk("t1_s_ready_wait", W'(s_ready), W'(0));
    chk("t1_size_held", W'(size), W'(3));
    chk("t1_lane2_held", d2, EC);
    repeat (4) step();
    pulse_done(H1);
    chk("t1_m_valid", W'(m_valid), W'(1));
    chk("t1_m_hash",  m_hash, H1);
    chk("t1_m_size",  W'(m_size), W'(3));
    chk("t1_m_err",   W'(m_err), W'(0));
    handshake();
    chk("t1_back_collect", W'(s_ready), W'(1));
    chk("t1_m_valid_low",  W'(m_valid), W'(0));

    // 2: seventeen beats -> overflow, first fifteen kept
    for (int i = 1; i <= 17; i++) beat(W'(i), (i == 17));
    chk("t2_start",  W'(start), W'(1));
    chk("t2_size",   W'(size),  W'(15));
    chk("t2_lane0",  d0,  W'(1));
    chk("t2_lane7",  d7,  W'(8));
    chk("t2_lane14", d14, W'(15));
    chk("t2_err_early", W'(m_err), W'(1));
    step();
    pulse_done(H2);
    chk("t2_m_hash", m_hash, H2);
    chk("t2_m_size", W'(m_size), W'(15));
    chk("t2_m_err",  W'(m_err), W'(1));
    handshake();
    chk("t2_err_cleared", W'(m_err), W'(0));

    // 3: single beat with last
    beat(EB, 1'b1);
    chk("t3_start", W'(start), W'(1));
    chk("t3_size",  W'(size),  W'(1));
    chk("t3_lane0", d0, EB);
    chk("t3_lane1", d1, '0);
    chk("t3_lane14", d14, '0);
    step();
    pulse_done(H1);
    chk("t3_m_size", W'(m_size), W'(1));
    handshake();

    // 4: stray done in COLLECT and in the FIRE cycle
    pulse_done(HX);
    chk("t4_collect_done_ignored", W'(m_valid), W'(0));
    chk("t4_still_collect", W'(s_ready), W'(1));
    beat(EC, 1'b1);
    chk("t4_fire", W'(start), W'(1));
    pulse_done(HX);
    chk("t4_fire_done_ignored", W'(m_valid), W'(0));
    step(); step();
    pulse_done(H2);
    chk("t4_m_valid", W'(m_valid), W'(1));
    chk("t4_m_hash", m_hash, H2);

    // 5: held result for 10 cycles, then two back-to-back messages
    held = m_hash;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t5_hold_valid_%0d", i), W'(m_valid), W'(1));
      chk($sformatf("t5_hold_hash_%0d", i), m_hash, held);
      chk($sformatf("t5_hold_sready_%0d", i), W'(s_ready), W'(0));
      step();
    end
    handshake();
    chk("t5_sready_after_hs", W'(s_ready), W'(1));
    beat(EA, 1'b0); beat(EB, 1'b1);
    chk("t5a_size", W'(size), W'(2));
    chk("t5a_lane1", d1, EB);
    chk("t5a_lane2", d2, '0);
    m_ready = 1'b1;
    step();
    pulse_done(H1);
    chk("t5a_m_valid", W'(m_valid), W'(1));
    chk("t5a_m_hash", m_hash, H1);
    step();
    m_ready = 1'b0;
    chk("t5a_fast_hs", W'(s_ready), W'(1));
    beat(EC, 1'b1);
    chk("t5b_size", W'(size), W'(1));
    chk("t5b_lane0", d0, EC);
    chk("t5b_lane1", d1, '0);
    step();
    pulse_done(H2);
    chk("t5b_m_hash", m_hash, H2);
    chk("t5b_m_size", W'(m_size), W'(1));
    handshake();

    // 6: reset while waiting, then the aborted run's done arrives
    beat(EA, 1'b0); beat(EB, 1'b1);
    step(); step();
    chk("t6_in_wait", W'(s_ready), W'(0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_s_ready", W'(s_ready), W'(1));
    chk("t6_start",   W'(start),   W'(0));
    chk("t6_size",    W'(size),    W'(0));
    chk("t6_lane0",   d0, '0);
    chk("t6_m_hash",  m_hash, '0);
    chk("t6_m_size",  W'(m_size), W'(0));
    pulse_done(HX);
    chk("t6_late_done", W'(m_valid), W'(0));
    chk("t6_hash_kept", m_hash, '0);

`ifdef POSEIDON2_REQ_TIMEOUT_EN
    beat(EA, 1'b1);
    step();
    begin
      int cyc = 0;
      while (!m_valid && cyc < 5000) begin step(); cyc++; end
      chk("t7_timeout_seen", W'(m_valid), W'(1));
    end
    chk("t7_m_err",  W'(m_err), W'(2));
    chk("t7_m_hash", m_hash, '0);
    handshake();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
